// File: rtl/viterbi_hd_k3.sv
// Hard-decision rate-1/2 K=3 Viterbi decoder (g0=111, g1=101), register-exchange survivors.
// Define VITERBI_ERRCNT_EN to add the err_cnt_o channel-error estimate output.
module viterbi_hd_k3 #(
    parameter int DEPTH = 16,
    parameter int PMW   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic [1:0] data_serial_i,
    input  logic       valid_serial_i,
    output logic       bit_o,
    output logic       bit_valid_o
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PMW-1:0] PM_INIT_OTHER = PMW'(7);

    logic [PMW-1:0]   pm_q     [4];
    logic [PMW-1:0]   pm_new   [4];
    logic [PMW-1:0]   pm_d     [4];
    logic [DEPTH-1:0] surv_q   [4];
    logic [DEPTH-1:0] surv_d   [4];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             bit_q;
    logic             bit_valid_q;
    logic             all_msb;
    logic [PMW-1:0]   min_new;
    logic [1:0]       best_state;

    // Hamming distance between the received pair and the encoder output {g0,g1}
    // produced when input u is applied in state p.
    function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic u,
                                                 input logic [1:0] p);
        logic [1:0] diff;
        diff = rx ^ {u ^ p[1] ^ p[0], u ^ p[0]};
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    // Add-compare-select: state {a,b} is reached from {b,0} or {b,1} with input a.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_acs
            localparam int   P0     = (gi % 2) * 2;
            localparam int   P1     = P0 + 1;
            localparam logic IN_BIT = (gi >= 2);

            logic [PMW-1:0] cand0;
            logic [PMW-1:0] cand1;
            logic           take1;

            assign cand0 = pm_q[P0] + PMW'(branch_metric(data_serial_i, IN_BIT, 2'(P0)));
            assign cand1 = pm_q[P1] + PMW'(branch_metric(data_serial_i, IN_BIT, 2'(P1)));
            assign take1 = (cand1 < cand0);

            assign pm_new[gi] = take1 ? cand1 : cand0;
            assign surv_d[gi] = {take1 ? surv_q[P1][DEPTH-2:0] : surv_q[P0][DEPTH-2:0], IN_BIT};
        end
    endgenerate

    // Dropping a shared MSB keeps the metric differences intact.
    assign all_msb = pm_new[0][PMW-1] & pm_new[1][PMW-1] & pm_new[2][PMW-1] & pm_new[3][PMW-1];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_norm
            assign pm_d[gi] = all_msb ? {1'b0, pm_new[gi][PMW-2:0]} : pm_new[gi];
        end
    endgenerate

    always_comb begin
        min_new    = pm_new[0];
        best_state = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (pm_new[i] < min_new) begin
                min_new    = pm_new[i];
                best_state = 2'(i);
            end
        end
    end

    assign cnt_d = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_INIT_OTHER;
                surv_q[i] <= '0;
            end
            cnt_q       <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
        end else if (clr_i) begin
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_INIT_OTHER;
                surv_q[i] <= '0;
            end
            cnt_q       <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
        end else if (valid_serial_i) begin
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= pm_d[i];
                surv_q[i] <= surv_d[i];
            end
            cnt_q <= cnt_d;
            if (cnt_d >= CW'(DEPTH)) begin
                bit_q       <= surv_d[best_state][DEPTH-1];
                bit_valid_q <= 1'b1;
            end else begin
                bit_valid_q <= 1'b0;
            end
        end else begin
            bit_valid_q <= 1'b0;
        end
    end

    assign bit_o       = bit_q;
    assign bit_valid_o = bit_valid_q;

`ifdef VITERBI_ERRCNT_EN
    logic [PMW-1:0] min_prev;
    logic [PMW-1:0] min_delta;
    logic [16:0]    err_sum;
    logic [15:0]    err_cnt_q;

    always_comb begin
        min_prev = pm_q[0];
        for (int i = 1; i < 4; i++) begin
            if (pm_q[i] < min_prev) begin
                min_prev = pm_q[i];
            end
        end
    end

    // The best metric never decreases, so this difference is the errors added by this symbol.
    assign min_delta = min_new - min_prev;
    assign err_sum   = {1'b0, err_cnt_q} + 17'(min_delta);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (clr_i) begin
            err_cnt_q <= '0;
        end else if (valid_serial_i) begin
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_hd_k3.sv
// Directed self-checking bench for viterbi_hd_k3 (DEPTH=16, PMW=6).
module tb_viterbi_hd_k3;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_i;
    logic [1:0] data_serial_i;
    logic       valid_serial_i;
    logic       bit_o;
    logic       bit_valid_o;
`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_cnt_o;
`endif

    int         n_total = 0;
    int         n_bad   = 0;
    int         n_strobe;
    logic [1:0] stim[$];
    logic       exp_bits[$];

    always #5 clk = ~clk;

    viterbi_hd_k3 #(.DEPTH(DEPTH), .PMW(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .clr_i          (clr_i),
        .data_serial_i  (data_serial_i),
        .valid_serial_i (valid_serial_i),
        .bit_o          (bit_o),
        .bit_valid_o    (bit_valid_o)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_cnt_o      (err_cnt_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] sym);
        valid_serial_i = 1'b1;
        data_serial_i  = sym;
        @(posedge clk);
        #1;
        valid_serial_i = 1'b0;
        data_serial_i  = 2'b00;
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_eq(tag, {31'd0, bit_valid_o}, 32'd0);
        end
    endtask

    task automatic clear_dut();
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        check_eq("clr_valid", {31'd0, bit_valid_o}, 32'd0);
        check_eq("clr_bit", {31'd0, bit_o}, 32'd0);
    endtask

    // Drives stim[], checks the strobe position after every symbol and each decoded bit.
    task automatic run_stim(input string tag, input bit gaps);
        n_strobe = 0;
        foreach (stim[i]) begin
            send(stim[i]);
            $display("[%s] sym %0d rx=%b strobe=%0d bit=%0d", tag, i, stim[i], bit_valid_o, bit_o);
            check_eq({tag, "_strobe"}, {31'd0, bit_valid_o}, ((i + 1) >= DEPTH) ? 32'd1 : 32'd0);
            if (bit_valid_o) begin
                if (n_strobe < exp_bits.size())
                    check_eq({tag, "_bit"}, {31'd0, bit_o}, {31'd0, exp_bits[n_strobe]});
                n_strobe++;
            end
            if (gaps) idle((i % 3) + 1, {tag, "_gap"});
        end
        check_eq({tag, "_count"}, n_strobe, stim.size() - DEPTH + 1);
    endtask

    task automatic load_codeword(input bit with_error);
        stim = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        if (with_error) stim[2] = 2'b10;
        repeat (20) stim.push_back(2'b00);
        exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        while (exp_bits.size() < stim.size() - DEPTH + 1) exp_bits.push_back(1'b0);
    endtask

    task automatic load_zeros(input int n);
        stim.delete();
        exp_bits.delete();
        repeat (n) stim.push_back(2'b00);
        repeat (n - DEPTH + 1) exp_bits.push_back(1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        clr_i          = 1'b0;
        valid_serial_i = 1'b0;
        data_serial_i  = 2'b11;

        // Reset held with valid toggling: outputs stay quiet.
        for (int c = 0; c < 3; c++) begin
            valid_serial_i = ~valid_serial_i;
            @(posedge clk);
            #1;
            $display("[reset] cycle %0d strobe=%0d bit=%0d", c, bit_valid_o, bit_o);
            check_eq("rst_valid", {31'd0, bit_valid_o}, 32'd0);
            check_eq("rst_bit", {31'd0, bit_o}, 32'd0);
        end
        valid_serial_i = 1'b0;
        rst            = 1'b0;

        load_zeros(20);
        run_stim("zeros", 1'b0);

        clear_dut();
        load_codeword(1'b0);
        run_stim("codeword", 1'b0);

        clear_dut();
        load_codeword(1'b1);
        run_stim("single_err", 1'b0);

        clear_dut();
        load_codeword(1'b0);
        run_stim("gaps", 1'b1);

        // All-ones input encodes to 11,01,10,10,...; clear lands on a valid symbol.
        clear_dut();
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 2'b11 : (i == 1) ? 2'b01 : 2'b10);
            $display("[preclr] sym %0d strobe=%0d", i, bit_valid_o);
            check_eq("preclr_strobe", {31'd0, bit_valid_o}, 32'd0);
        end
        clr_i          = 1'b1;
        valid_serial_i = 1'b1;
        data_serial_i  = 2'b11;
        @(posedge clk);
        #1;
        clr_i          = 1'b0;
        valid_serial_i = 1'b0;
        check_eq("midclr_valid", {31'd0, bit_valid_o}, 32'd0);
        check_eq("midclr_bit", {31'd0, bit_o}, 32'd0);
        load_zeros(20);
        run_stim("postclr", 1'b0);

`ifdef VITERBI_ERRCNT_EN
        clear_dut();
        check_eq("errcnt_clr", {16'd0, err_cnt_o}, 32'd0);
        load_zeros(30);
        stim[20] = 2'b01;
        run_stim("errcnt", 1'b0);
        check_eq("errcnt_final", {16'd0, err_cnt_o}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
